// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority over a
// queued long-latency result; a busy scoreboard raises hazard/starve stalls.
module regfile_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_wb_we,
    input  logic [4:0]  i_wb_waddr,
    input  logic [31:0] i_wb_wdata,
    input  logic        i_lu_valid,
    input  logic [4:0]  i_lu_waddr,
    input  logic [31:0] i_lu_wdata,
    output logic        o_lu_ready,
    input  logic        i_issue_valid,
    input  logic [4:0]  i_issue_waddr,
    input  logic        i_chk_re1,
    input  logic [4:0]  i_chk_raddr1,
    input  logic        i_chk_re2,
    input  logic [4:0]  i_chk_raddr2,
    output logic        o_rf_we,
    output logic [4:0]  o_rf_waddr,
    output logic [31:0] o_rf_wdata,
    output logic        o_stallreq
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [4:0]    r_addr [DEPTH];
    logic [31:0]   r_data [DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;
    logic [31:0]   r_busy;
    logic [SW-1:0] r_starve;

    logic          w_empty;
    logic          w_full;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head_addr;
    logic [31:0]   w_head_data;
    logic          w_starve;
    logic          w_hz;
    logic          w_set;
    logic [31:0]   w_busy_nxt;

    assign w_empty     = (r_count == '0);
    assign w_full      = (r_count == CW'(DEPTH));
    assign w_head_addr = r_addr[r_rd_ptr];
    assign w_head_data = r_data[r_rd_ptr];
    assign w_starve    = (r_starve == SW'(STARVE_MAX));

    // Ready depends only on registered occupancy, never on i_lu_valid.
    assign o_lu_ready = !rst && !w_full;
    assign w_push     = i_lu_valid && o_lu_ready;
    assign w_pop      = !rst && !i_wb_we && !w_empty;

    assign w_hz = (i_chk_re1 && r_busy[i_chk_raddr1])
                | (i_chk_re2 && r_busy[i_chk_raddr2])
                | (i_issue_valid && r_busy[i_issue_waddr]);

    assign o_stallreq = !rst && (w_hz || w_starve);
    assign w_set      = i_issue_valid && (i_issue_waddr != 5'd0) && !o_stallreq;

    always_comb begin
        o_rf_we    = 1'b0;
        o_rf_waddr = 5'd0;
        o_rf_wdata = 32'd0;
        if (!rst) begin
            if (i_wb_we) begin
                o_rf_we    = 1'b1;
                o_rf_waddr = i_wb_waddr;
                o_rf_wdata = i_wb_wdata;
            end else if (w_pop) begin
                o_rf_we    = (w_head_addr != 5'd0);
                o_rf_waddr = w_head_addr;
                o_rf_wdata = w_head_data;
            end
        end
    end

    // Clear first so that a same-cycle issue to that register keeps it busy.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_pop) begin
            w_busy_nxt[w_head_addr] = 1'b0;
        end
        if (w_set) begin
            w_busy_nxt[i_issue_waddr] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_addr[r_wr_ptr] <= i_lu_waddr;
            r_data[r_wr_ptr] <= i_lu_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            r_busy   <= '0;
            r_starve <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            r_busy  <= w_busy_nxt;
            if (w_empty || w_pop) begin
                r_starve <= '0;
            end else if (!w_starve) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter.
// Inputs change on the falling edge; outputs are compared 1 ns later.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        lu_valid;
    logic [4:0]  lu_waddr;
    logic [31:0] lu_wdata;
    logic        lu_ready;
    logic        issue_valid;
    logic [4:0]  issue_waddr;
    logic        chk_re1;
    logic [4:0]  chk_raddr1;
    logic        chk_re2;
    logic [4:0]  chk_raddr2;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        stallreq;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    regfile_wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_wb_we      (wb_we),
        .i_wb_waddr   (wb_waddr),
        .i_wb_wdata   (wb_wdata),
        .i_lu_valid   (lu_valid),
        .i_lu_waddr   (lu_waddr),
        .i_lu_wdata   (lu_wdata),
        .o_lu_ready   (lu_ready),
        .i_issue_valid(issue_valid),
        .i_issue_waddr(issue_waddr),
        .i_chk_re1    (chk_re1),
        .i_chk_raddr1 (chk_raddr1),
        .i_chk_re2    (chk_re2),
        .i_chk_raddr2 (chk_raddr2),
        .o_rf_we      (rf_we),
        .o_rf_waddr   (rf_waddr),
        .o_rf_wdata   (rf_wdata),
        .o_stallreq   (stallreq)
    );

    typedef struct {
        logic        rst;
        logic        wbwe;
        logic [4:0]  wba;
        logic [31:0] wbd;
        logic        luv;
        logic [4:0]  lua;
        logic [31:0] lud;
        logic        iv;
        logic [4:0]  ia;
        logic        re1;
        logic [4:0]  ra1;
        logic        re2;
        logic [4:0]  ra2;
        logic        erwe;
        logic [4:0]  era;
        logic [31:0] erd;
        logic        elr;
        logic        est;
    } vec_t;

    vec_t tbl[$];

    task automatic add(
        input logic r, input logic we, input logic [4:0] wa,
        input logic [31:0] wd, input logic lv, input logic [4:0] la,
        input logic [31:0] ld, input logic iv, input logic [4:0] ia,
        input logic e1, input logic [4:0] a1, input logic e2,
        input logic [4:0] a2, input logic xwe, input logic [4:0] xa,
        input logic [31:0] xd, input logic xlr, input logic xst);
        vec_t t;
        t.rst = r;   t.wbwe = we; t.wba = wa;  t.wbd = wd;
        t.luv = lv;  t.lua = la;  t.lud = ld;  t.iv = iv;
        t.ia = ia;   t.re1 = e1;  t.ra1 = a1;  t.re2 = e2;
        t.ra2 = a2;  t.erwe = xwe; t.era = xa; t.erd = xd;
        t.elr = xlr; t.est = xst;
        tbl.push_back(t);
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run(input string tag, input int idx, input vec_t t);
        @(negedge clk);
        rst         = t.rst;
        wb_we       = t.wbwe;
        wb_waddr    = t.wba;
        wb_wdata    = t.wbd;
        lu_valid    = t.luv;
        lu_waddr    = t.lua;
        lu_wdata    = t.lud;
        issue_valid = t.iv;
        issue_waddr = t.ia;
        chk_re1     = t.re1;
        chk_raddr1  = t.ra1;
        chk_re2     = t.re2;
        chk_raddr2  = t.ra2;
        #1;
        chk($sformatf("%s%0d rf_we", tag, idx), 32'(rf_we), 32'(t.erwe));
        chk($sformatf("%s%0d lu_ready", tag, idx), 32'(lu_ready), 32'(t.elr));
        chk($sformatf("%s%0d stallreq", tag, idx), 32'(stallreq), 32'(t.est));
        if (t.erwe || t.rst) begin
            chk($sformatf("%s%0d rf_waddr", tag, idx), 32'(rf_waddr), 32'(t.era));
            chk($sformatf("%s%0d rf_wdata", tag, idx), rf_wdata, t.erd);
        end
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_waddr = '0; wb_wdata = '0;
        lu_valid = 1'b0; lu_waddr = '0; lu_wdata = '0;
        issue_valid = 1'b0; issue_waddr = '0;
        chk_re1 = 1'b0; chk_raddr1 = '0; chk_re2 = 1'b0; chk_raddr2 = '0;

        // reset with live requests
        for (int i = 0; i < 3; i++)
            add(1,1,7,1, 1,3,2, 1,5, 0,0,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,5,1,31, 0,0,0,1,0);
        // basic long-latency write; issue to 6 while stalled is dropped
        add(0,0,0,0, 0,0,0, 1,5, 0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,6, 1,5,0,0, 0,0,0,1,1);
        add(0,0,0,0, 1,5,32'hDEADBEEF, 0,0, 1,5,0,0, 0,0,0,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 1,5,0,0, 1,5,32'hDEADBEEF,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 1,5,1,6, 0,0,0,1,0);
        // wb priority, FIFO fill, in-order drain
        add(0,1,7,32'h11111111, 1,3,32'h33333333, 0,0, 0,0,0,0,
            1,7,32'h11111111,1,0);
        add(0,1,7,32'h22222222, 1,4,32'h44444444, 0,0, 0,0,0,0,
            1,7,32'h22222222,1,0);
        add(0,1,7,32'h77777777, 0,0,0, 0,0, 0,0,0,0, 1,7,32'h77777777,0,0);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,3,32'h33333333,0,0);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,4,32'h44444444,1,0);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0);
        // starvation
        add(0,1,8,32'h88, 1,10,32'hAAAA0000, 0,0, 0,0,0,0, 1,8,32'h88,1,0);
        for (int i = 0; i < 4; i++)
            add(0,1,8,32'h88, 0,0,0, 0,0, 0,0,0,0, 1,8,32'h88,1,0);
        for (int i = 0; i < 2; i++)
            add(0,1,8,32'h88, 0,0,0, 0,0, 0,0,0,0, 1,8,32'h88,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,10,32'hAAAA0000,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0);
        // same-cycle set and clear on reg 9
        add(0,0,0,0, 1,9,32'h99, 0,0, 0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 1,9, 0,0,0,0, 1,9,32'h99,1,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,9,0,0, 0,0,0,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,1,9, 0,0,0,1,1);
        // register 0 entry pops silently; wb to reg 0 passes through
        add(0,0,0,0, 1,0,32'h12345678, 0,0, 0,0,0,0, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0);
        add(0,1,0,32'h55, 1,12,32'hC0C0C0C0, 1,0, 0,0,0,0, 1,0,32'h55,1,0);
        add(0,1,0,32'h56, 1,13,32'h0D, 0,0, 0,0,0,0, 1,0,32'h56,1,0);
        add(0,1,0,32'h57, 0,0,0, 1,3, 0,0,0,0, 1,0,32'h57,0,0);
        add(0,1,0,32'h58, 0,0,0, 1,4, 0,0,0,0, 1,0,32'h58,0,0);
        // reset mid-operation
        add(1,1,0,32'h59, 0,0,0, 0,0, 1,3,0,0, 0,0,0,0,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,3,1,4, 0,0,0,1,0);
        add(0,0,0,0, 0,0,0, 0,0, 1,9,0,0, 0,0,0,1,0);

        for (int i = 0; i < tbl.size(); i++)
            run("v", i, tbl[i]);

        // long starvation: counter saturates and the stall holds until a pop
        tbl.delete();
        add(0,1,1,32'h0, 1,20,32'hBEEF, 0,0, 0,0,0,0, 1,1,32'h0,1,0);
        for (int i = 1; i <= 10; i++)
            add(0,1,1,32'(i), 0,0,0, 0,0, 0,0,0,0,
                1,1,32'(i),1,(i >= 5));
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 1,20,32'hBEEF,1,1);
        add(0,0,0,0, 0,0,0, 0,0, 0,0,0,0, 0,0,0,1,0);
        for (int i = 0; i < tbl.size(); i++)
            run("s", i, tbl[i]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
